// File: rtl/display_pkg.sv
// Shared constants and types for the multiplexed hex display controller.
package display_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam logic [6:0]  SEG_BLANK  = 7'h7F;

    typedef enum logic {
        IDLE,
        UPDATE
    } state_t;

    typedef logic [1:0] digit_idx_t;

endpackage

// File: rtl/B_7SegDec.sv
// Hex nibble to active-low 7-segment pattern (bit0=a ... bit6=g).
module B_7SegDec (
    input  logic [3:0] i_hex,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = 7'h7F;
        case (i_hex)
            4'h0: o_seg = 7'b1000000;
            4'h1: o_seg = 7'b1111001;
            4'h2: o_seg = 7'b0100100;
            4'h3: o_seg = 7'b0110000;
            4'h4: o_seg = 7'b0011001;
            4'h5: o_seg = 7'b0010010;
            4'h6: o_seg = 7'b0000010;
            4'h7: o_seg = 7'b1111000;
            4'h8: o_seg = 7'b0000000;
            4'h9: o_seg = 7'b0010000;
            4'hA: o_seg = 7'b0001000;
            4'hB: o_seg = 7'b0000011;
            4'hC: o_seg = 7'b1000110;
            4'hD: o_seg = 7'b0100001;
            4'hE: o_seg = 7'b0000110;
            4'hF: o_seg = 7'b0001110;
            default: o_seg = 7'h7F;
        endcase
    end

endmodule

// File: rtl/hex_display_scan_ctrl.sv
// Walks four hex digits through one shared 7-segment decoder, one digit per scan tick,
// with a one-deep pending buffer so back-to-back loads run without idle cycles.
module hex_display_scan_ctrl
    import display_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 1,
    parameter bit          LZ_BLANK = 1'b0
) (
    input  logic        CLOCK_50,
    input  logic        Resetn,
    input  logic [15:0] data_in,
    input  logic [3:0]  blank_in,
    input  logic        load,
    output logic        ready,
    output logic        done,
    output logic [6:0]  HEX0,
    output logic [6:0]  HEX1,
    output logic [6:0]  HEX2,
    output logic [6:0]  HEX3
);

    localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    digit_idx_t       r_idx;
    logic [15:0]      r_work;
    logic [3:0]       r_work_blank;
    logic [15:0]      r_pend;
    logic [3:0]       r_pend_blank;
    logic             r_pend_vld;
    logic             r_done;
    logic [6:0]       r_hex [NUM_DIGITS];

    logic             w_tick;
    logic             w_pass_end;
    logic [15:0]      w_shifted;
    logic             w_lz;
    logic [6:0]       w_dec;
    logic [6:0]       w_seg;

    // Shifting the work word down leaves the selected nibble in [3:0] and zero above it
    // exactly when this digit and all higher digits are zero.
    assign w_shifted = r_work >> {r_idx, 2'b00};
    assign w_lz      = LZ_BLANK && (r_idx != 2'd0) && (w_shifted == 16'h0000);

    B_7SegDec u_dec (
        .i_hex (w_shifted[3:0]),
        .o_seg (w_dec)
    );

    always_comb begin
        w_seg = w_dec;
        if (r_work_blank[r_idx] || w_lz) begin
            w_seg = SEG_BLANK;
        end
    end

    assign w_tick     = (r_state == UPDATE) && (r_cnt == CNT_MAX);
    assign w_pass_end = w_tick && (r_idx == 2'd3);

    always_ff @(posedge CLOCK_50) begin
        if (!Resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (load) begin
                    w_state_next = UPDATE;
                end
            end
            UPDATE: begin
                if (w_pass_end && !r_pend_vld && !load) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (!Resetn) begin
            r_cnt        <= '0;
            r_idx        <= '0;
            r_work       <= '0;
            r_work_blank <= '0;
            r_pend       <= '0;
            r_pend_blank <= '0;
            r_pend_vld   <= 1'b0;
            r_done       <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                r_hex[i] <= SEG_BLANK;
            end
        end else begin
            r_done <= w_pass_end;
            if (r_state == IDLE) begin
                if (load) begin
                    r_work       <= data_in;
                    r_work_blank <= blank_in;
                    r_idx        <= '0;
                    r_cnt        <= '0;
                end
            end else begin
                r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
                if (w_tick) begin
                    r_hex[r_idx] <= w_seg;
                    r_idx        <= r_idx + 2'd1;
                end
                if (w_pass_end) begin
                    // A load on the pass-end edge queues behind any value already pending.
                    if (r_pend_vld) begin
                        r_work       <= r_pend;
                        r_work_blank <= r_pend_blank;
                        r_pend_vld   <= load;
                        if (load) begin
                            r_pend       <= data_in;
                            r_pend_blank <= blank_in;
                        end
                    end else if (load) begin
                        r_work       <= data_in;
                        r_work_blank <= blank_in;
                    end
                end else if (load) begin
                    r_pend       <= data_in;
                    r_pend_blank <= blank_in;
                    r_pend_vld   <= 1'b1;
                end
            end
        end
    end

    assign ready = (r_state == IDLE) && !r_done;
    assign done  = r_done;
    assign HEX0  = r_hex[0];
    assign HEX1  = r_hex[1];
    assign HEX2  = r_hex[2];
    assign HEX3  = r_hex[3];

endmodule

// File: tb/tb_hex_display_scan_ctrl.sv
// Bench for hex_display_scan_ctrl: two configurations checked every cycle against a
// transaction-level model, plus directed checks of the documented scenarios.
module tb_hex_display_scan_ctrl;

    localparam int unsigned DIV_A = 1;
    localparam int unsigned DIV_B = 3;

    logic        CLOCK_50 = 1'b0;
    logic        Resetn;
    logic [15:0] data_in;
    logic [3:0]  blank_in;
    logic        load;

    logic       ready_a, done_a, ready_b, done_b;
    logic [6:0] hx_a [4];
    logic [6:0] hx_b [4];

    int total = 0;
    int bad   = 0;
    int done_cnt_a = 0;
    int done_cnt_b = 0;
    bit seen_one = 1'b0;

    always #10 CLOCK_50 = ~CLOCK_50;

    hex_display_scan_ctrl #(.SCAN_DIV(DIV_A), .LZ_BLANK(1'b0)) u_dut_a (
        .CLOCK_50 (CLOCK_50),
        .Resetn   (Resetn),
        .data_in  (data_in),
        .blank_in (blank_in),
        .load     (load),
        .ready    (ready_a),
        .done     (done_a),
        .HEX0     (hx_a[0]),
        .HEX1     (hx_a[1]),
        .HEX2     (hx_a[2]),
        .HEX3     (hx_a[3])
    );

    hex_display_scan_ctrl #(.SCAN_DIV(DIV_B), .LZ_BLANK(1'b1)) u_dut_b (
        .CLOCK_50 (CLOCK_50),
        .Resetn   (Resetn),
        .data_in  (data_in),
        .blank_in (blank_in),
        .load     (load),
        .ready    (ready_b),
        .done     (done_b),
        .HEX0     (hx_b[0]),
        .HEX1     (hx_b[1]),
        .HEX2     (hx_b[2]),
        .HEX3     (hx_b[3])
    );

    logic [6:0] seg_tbl [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    // Model state: index 0 = config A, 1 = config B.
    int unsigned m_div  [2] = '{DIV_A, DIV_B};
    bit          m_lz   [2] = '{1'b0, 1'b1};
    logic [6:0]  m_hex  [2][4];
    bit          m_busy [2];
    int unsigned m_t    [2];
    logic [15:0] m_work [2];
    logic [3:0]  m_wbl  [2];
    logic [15:0] m_pend [2];
    logic [3:0]  m_pbl  [2];
    bit          m_pv   [2];
    bit          m_done [2];

    function automatic logic [6:0] ref_seg(logic [15:0] v, logic [3:0] bl, int d, bit lz);
        logic [15:0] up;
        up = v >> (4 * d);
        if (bl[d]) return 7'h7F;
        if (lz && d > 0 && up == 16'h0) return 7'h7F;
        return seg_tbl[up[3:0]];
    endfunction

    task automatic model_step(int k);
        bit endp;
        int d;
        if (!Resetn) begin
            for (int i = 0; i < 4; i++) m_hex[k][i] = 7'h7F;
            m_busy[k] = 0; m_t[k] = 0; m_pv[k] = 0; m_done[k] = 0;
            m_work[k] = '0; m_wbl[k] = '0; m_pend[k] = '0; m_pbl[k] = '0;
            return;
        end
        endp = 0;
        if (!m_busy[k]) begin
            if (load) begin
                m_work[k] = data_in; m_wbl[k] = blank_in; m_busy[k] = 1; m_t[k] = 0;
            end
        end else begin
            m_t[k]++;
            if (m_t[k] % m_div[k] == 0) begin
                d = int'(m_t[k] / m_div[k]) - 1;
                m_hex[k][d] = ref_seg(m_work[k], m_wbl[k], d, m_lz[k]);
                endp = (d == 3);
            end
            if (endp) begin
                m_t[k] = 0;
                if (m_pv[k]) begin
                    m_work[k] = m_pend[k]; m_wbl[k] = m_pbl[k]; m_pv[k] = 0;
                    if (load) begin
                        m_pend[k] = data_in; m_pbl[k] = blank_in; m_pv[k] = 1;
                    end
                end else if (load) begin
                    m_work[k] = data_in; m_wbl[k] = blank_in;
                end else begin
                    m_busy[k] = 0;
                end
            end else if (load) begin
                m_pend[k] = data_in; m_pbl[k] = blank_in; m_pv[k] = 1;
            end
        end
        m_done[k] = endp;
    endtask

    always @(posedge CLOCK_50) begin
        model_step(0);
        model_step(1);
    end

    task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("a.hex%0d", i), {9'd0, hx_a[i]}, {9'd0, m_hex[0][i]});
            chk($sformatf("b.hex%0d", i), {9'd0, hx_b[i]}, {9'd0, m_hex[1][i]});
        end
        chk("a.done",  {15'd0, done_a},  {15'd0, m_done[0]});
        chk("b.done",  {15'd0, done_b},  {15'd0, m_done[1]});
        chk("a.ready", {15'd0, ready_a}, {15'd0, !m_busy[0] && !m_done[0]});
        chk("b.ready", {15'd0, ready_b}, {15'd0, !m_busy[1] && !m_done[1]});
    endtask

    task automatic tick();
        @(negedge CLOCK_50);
        check_all();
        if (done_a) done_cnt_a++;
        if (done_b) done_cnt_b++;
        if (hx_a[0] === 7'b1111001 || hx_b[0] === 7'b1111001) seen_one = 1'b1;
    endtask

    task automatic wait_idle(string tag);
        int n;
        n = 0;
        while (!(ready_a && ready_b) && n < 200) begin
            tick();
            n++;
        end
        chk({tag, ".idle_timeout"}, {15'd0, n < 200}, 16'd1);
    endtask

    task automatic do_load(logic [15:0] d, logic [3:0] b);
        data_in  = d;
        blank_in = b;
        load     = 1'b1;
        tick();
        load     = 1'b0;
    endtask

    initial begin
        Resetn = 1'b0; load = 1'b0; data_in = '0; blank_in = '0;

        // Reset held for three cycles
        repeat (3) tick();
        chk("rst.hex0", {9'd0, hx_a[0]}, 16'h7F);
        chk("rst.hex3", {9'd0, hx_b[3]}, 16'h7F);
        chk("rst.ready", {15'd0, ready_a}, 16'd1);
        chk("rst.done", {15'd0, done_b}, 16'd0);
        Resetn = 1'b1;
        tick();

        // Single pass 16'h1234, latency on config A
        do_load(16'h1234, 4'b0000);
        tick(); chk("p1234.hex0_t1", {9'd0, hx_a[0]}, {9'd0, 7'b0011001});
        tick(); chk("p1234.hex1_t2", {9'd0, hx_a[1]}, {9'd0, 7'b0110000});
        tick(); chk("p1234.hex2_t3", {9'd0, hx_a[2]}, {9'd0, 7'b0100100});
        chk("p1234.done_t3", {15'd0, done_a}, 16'd0);
        tick(); chk("p1234.hex3_t4", {9'd0, hx_a[3]}, {9'd0, 7'b1111001});
        chk("p1234.done_t4", {15'd0, done_a}, 16'd1);
        chk("p1234.ready_t4", {15'd0, ready_a}, 16'd0);
        tick(); chk("p1234.done_t5", {15'd0, done_a}, 16'd0);
        chk("p1234.ready_t5", {15'd0, ready_a}, 16'd1);
        wait_idle("p1234");

        // Force-blank mask
        do_load(16'h0008, 4'b0001);
        wait_idle("blank");
        chk("blank.hex0", {9'd0, hx_a[0]}, 16'h7F);
        chk("blank.hex1", {9'd0, hx_a[1]}, {9'd0, 7'b1000000});

        // Leading-zero suppression on config B
        do_load(16'h0050, 4'b0000);
        wait_idle("lz");
        chk("lz.hex3", {9'd0, hx_b[3]}, 16'h7F);
        chk("lz.hex2", {9'd0, hx_b[2]}, 16'h7F);
        chk("lz.hex1", {9'd0, hx_b[1]}, {9'd0, 7'b0010010});
        chk("lz.hex0", {9'd0, hx_b[0]}, {9'd0, 7'b1000000});
        chk("lz.a_hex3", {9'd0, hx_a[3]}, {9'd0, 7'b1000000});

        // Prescaler timing on config B (SCAN_DIV=3)
        do_load(16'hFFFF, 4'b0000);
        for (int c = 1; c <= 13; c++) begin
            tick();
            if (c == 2)  chk("div.hex0_t2", {9'd0, hx_b[0]}, {9'd0, 7'b1000000});
            if (c == 3)  chk("div.hex0_t3", {9'd0, hx_b[0]}, {9'd0, 7'b0001110});
            if (c == 11) chk("div.hex3_t11", {9'd0, hx_b[3]}, 16'h7F);
            if (c == 11) chk("div.done_t11", {15'd0, done_b}, 16'd0);
            if (c == 12) chk("div.hex3_t12", {9'd0, hx_b[3]}, {9'd0, 7'b0001110});
            if (c == 12) chk("div.done_t12", {15'd0, done_b}, 16'd1);
            if (c == 13) chk("div.done_t13", {15'd0, done_b}, 16'd0);
        end
        wait_idle("div");

        // Pending buffer: last load wins, 1111 never shown
        done_cnt_a = 0; done_cnt_b = 0; seen_one = 1'b0;
        do_load(16'hAAAA, 4'b0000);
        tick();
        do_load(16'h1111, 4'b0000);
        data_in = 16'hFFFF; load = 1'b1;
        tick();
        load = 1'b0;
        wait_idle("pend");
        repeat (2) tick();
        chk("pend.a_dones", 16'(done_cnt_a), 16'd2);
        chk("pend.b_dones", 16'(done_cnt_b), 16'd2);
        chk("pend.no_1111", {15'd0, seen_one}, 16'd0);
        chk("pend.a_hex0", {9'd0, hx_a[0]}, {9'd0, 7'b0001110});
        chk("pend.a_hex3", {9'd0, hx_a[3]}, {9'd0, 7'b0001110});

        // Reset mid-pass, then a clean pass
        done_cnt_a = 0;
        do_load(16'h1234, 4'b0000);
        tick();
        Resetn = 1'b0;
        tick();
        chk("mid.hex0", {9'd0, hx_a[0]}, 16'h7F);
        chk("mid.hex1", {9'd0, hx_a[1]}, 16'h7F);
        chk("mid.done", {15'd0, done_a}, 16'd0);
        Resetn = 1'b1;
        repeat (4) tick();
        chk("mid.no_done", 16'(done_cnt_a), 16'd0);
        do_load(16'h4321, 4'b0000);
        wait_idle("mid_after");
        chk("mid.after_hex3", {9'd0, hx_a[3]}, {9'd0, 7'b0011001});
        chk("mid.after_hex0", {9'd0, hx_a[0]}, {9'd0, 7'b1111001});

        // Random traffic against the model
        for (int c = 0; c < 600; c++) begin
            load     = ($urandom_range(0, 3) == 0);
            data_in  = 16'($urandom);
            if ($urandom_range(0, 1) == 0) data_in[15:8] = 8'h00;
            blank_in = 4'($urandom) & 4'($urandom);
            Resetn   = ($urandom_range(0, 99) != 0);
            tick();
        end
        Resetn = 1'b1; load = 1'b0;
        wait_idle("rand");
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
